fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the single-operand valA forwarding select.
- Forwards both decode operands (valA, valB) from the E/M/W stages.
- Qualifies every match against RNONE so that unused sources never forward.
- Detects load-use hazards, produces the stall/bubble controls, and registers the selected operands into the E stage.
- Keeps saturating stall and forward-hit counters for performance debug.
- Sits between decode and the D→E pipeline register of the Y86 five-stage core.

Parameters:
- DATA_W, 64, operand/value width
- REG_W, 4, register-ID width
- RNONE, 4'hF, "no register" encoding; never matches
- CNT_W, 32, width of the performance counters

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- D_icode_i  in  4  decode-stage icode
- D_valP_i  in  DATA_W  decode-stage valP
- d_srcA_i  in  REG_W  decode srcA
- d_srcB_i  in  REG_W  decode srcB
- d_rvalA_i  in  DATA_W  register-file read A
- d_rvalB_i  in  DATA_W  register-file read B
- E_icode_i  in  4  icode currently in E
- E_dstM_i  in  REG_W  dstM currently in E (load-use check)
- e_dstE_i  in  REG_W  execute-stage dstE
- e_valE_i  in  DATA_W  execute-stage valE
- M_dstM_i  in  REG_W  memory-stage dstM
- m_valM_i  in  DATA_W  memory-stage valM
- M_dstE_i  in  REG_W  memory-stage dstE
- M_valE_i  in  DATA_W  memory-stage valE
- W_dstM_i  in  REG_W  writeback-stage dstM
- W_valM_i  in  DATA_W  writeback-stage valM
- W_dstE_i  in  REG_W  writeback-stage dstE
- W_valE_i  in  DATA_W  writeback-stage valE
- E_bubble_i  in  1  external bubble request (mispredict)
- cnt_clr_i  in  1  synchronous counter clear
- d_valA_o  out  DATA_W  combinational forwarded valA
- d_valB_o  out  DATA_W  combinational forwarded valB
- E_valA_o  out  DATA_W  registered valA for E
- E_valB_o  out  DATA_W  registered valB for E
- E_nop_o  out  1  registered: E slot holds a bubble
- D_stall_o  out  1  combinational: hold F and D
- stall_cnt_o  out  CNT_W  load-use stall cycles
- fwd_cnt_o  out  CNT_W  cycles in which any operand was forwarded

Behaviour:
- valA priority, first match wins:
  - (D_icode==CALL or JXX) → D_valP.
  - Else srcA==e_dstE → e_valE.
  - Else ==M_dstM → m_valM.
  - Else ==M_dstE → M_valE.
  - Else ==W_dstM → W_valM.
  - Else ==W_dstE → W_valE.
  - Else → d_rvalA.
- valB: same chain without the valP term, using srcB/d_rvalB.
- A source equal to RNONE never matches. A destination equal to RNONE never matches.
- loaduse = E_icode∈{MRMOVQ,POPQ}, E_dstM≠RNONE, and E_dstM equals a non-RNONE d_srcA or d_srcB.
- D_stall_o = loaduse, combinational, same cycle.
- E register update (rising edge):
  - If !rst_n_i: E_valA=0, E_valB=0, E_nop=1.
  - Else if loaduse or E_bubble_i: E_valA=0, E_valB=0, E_nop=1.
  - Else: E_valA=d_valA, E_valB=d_valB, E_nop=0.
  - Latency is one cycle from d_* to E_*.
- loaduse and E_bubble_i in the same cycle produce a single bubble. The stall counter still increments.
- Counter precedence: reset > cnt_clr_i > increment.
  - Both counters saturate at all-ones and never wrap.
- stall_cnt increments when loaduse=1.
- fwd_cnt increments when loaduse=0, E_bubble_i=0, and valA or valB comes from an E/M/W source.
  - The valP selection does not count as a forward.
- Reset clears both counters to 0.
  - Reset asserted mid-stall wins: the outputs take reset values and D_stall_o still follows its inputs combinationally.
- X-free: every output is defined when every input is known.

Decomposition:
- define.v (shared) holds: icode constants (CALL, JXX, MRMOVQ, POPQ) and RNONE.
- Sub-module fwd_sel_chain, instantiated twice: parameters DATA_W, REG_W, RNONE, USE_VALP; output hit flag plus selected value.
- The top level holds the hazard logic, the E register and the counters.

Test Plan:
- srcA=3, e_dstE=3, e_valE=0x11, M_dstE=3, M_valE=0x22 → d_valA=0x11; next edge E_valA=0x11, fwd_cnt=1.
- srcB=RNONE, all dst=RNONE, d_rvalB=0x55 → d_valB=0x55; fwd_cnt unchanged.
- E_icode=MRMOVQ, E_dstM=2, srcB=2 → D_stall_o=1; next edge E_nop=1, E_valB=0, stall_cnt=1. Next cycle E_icode=NOP, M_dstM=2, m_valM=0x77 → E_valB=0x77.
- D_icode=CALL, D_valP=0x40, srcA=4=e_dstE → d_valA=0x40; fwd_cnt does not increment unless valB forwards.
- Preload stall_cnt to all-ones via a long stall run with CNT_W=4: after 15 stall cycles the count holds at 15; cnt_clr_i → 0.
- rst_n_i=0 during an active load-use → E_nop=1, E_valA=E_valB=0, counters=0 on that edge.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared Y86 encodings for the forwarding / hazard unit.
package fwd_hazard_unit_pkg;

    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Register ID meaning "no register"; it never matches anything.
    localparam logic [3:0] RNONE_ID     = 4'hF;

    // True for instructions whose result only becomes available after memory.
    function automatic logic is_load(input logic [3:0] icode);
        return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle between the D stage, the pipeline and the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 32
);
    import fwd_hazard_unit_pkg::*;

    logic [3:0]        D_icode_i;
    logic [DATA_W-1:0] D_valP_i;
    logic [REG_W-1:0]  d_srcA_i;
    logic [REG_W-1:0]  d_srcB_i;
    logic [DATA_W-1:0] d_rvalA_i;
    logic [DATA_W-1:0] d_rvalB_i;
    logic [3:0]        E_icode_i;
    logic [REG_W-1:0]  E_dstM_i;
    logic [REG_W-1:0]  e_dstE_i;
    logic [DATA_W-1:0] e_valE_i;
    logic [REG_W-1:0]  M_dstM_i;
    logic [DATA_W-1:0] m_valM_i;
    logic [REG_W-1:0]  M_dstE_i;
    logic [DATA_W-1:0] M_valE_i;
    logic [REG_W-1:0]  W_dstM_i;
    logic [DATA_W-1:0] W_valM_i;
    logic [REG_W-1:0]  W_dstE_i;
    logic [DATA_W-1:0] W_valE_i;
    logic              E_bubble_i;
    logic              cnt_clr_i;
    logic [DATA_W-1:0] d_valA_o;
    logic [DATA_W-1:0] d_valB_o;
    logic [DATA_W-1:0] E_valA_o;
    logic [DATA_W-1:0] E_valB_o;
    logic              E_nop_o;
    logic              D_stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  fwd_cnt_o;

    modport master (
        output D_icode_i, D_valP_i, d_srcA_i, d_srcB_i, d_rvalA_i, d_rvalB_i,
               E_icode_i, E_dstM_i, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i,
               M_dstE_i, M_valE_i, W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
               E_bubble_i, cnt_clr_i,
        input  d_valA_o, d_valB_o, E_valA_o, E_valB_o, E_nop_o, D_stall_o,
               stall_cnt_o, fwd_cnt_o
    );

    modport slave (
        input  D_icode_i, D_valP_i, d_srcA_i, d_srcB_i, d_rvalA_i, d_rvalB_i,
               E_icode_i, E_dstM_i, e_dstE_i, e_valE_i, M_dstM_i, m_valM_i,
               M_dstE_i, M_valE_i, W_dstM_i, W_valM_i, W_dstE_i, W_valE_i,
               E_bubble_i, cnt_clr_i,
        output d_valA_o, d_valB_o, E_valA_o, E_valB_o, E_nop_o, D_stall_o,
               stall_cnt_o, fwd_cnt_o
    );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel_chain.sv
// Priority forwarding select for one decode operand (E > M > W > regfile).
module fwd_sel_chain
    import fwd_hazard_unit_pkg::*;
#(
    parameter int               DATA_W   = 64,
    parameter int               REG_W    = 4,
    parameter logic [REG_W-1:0] RNONE    = RNONE_ID,
    parameter bit               USE_VALP = 1'b0
) (
    input  logic [3:0]        icode,
    input  logic [DATA_W-1:0] valp,
    input  logic [REG_W-1:0]  src,
    input  logic [DATA_W-1:0] rval,
    input  logic [REG_W-1:0]  e_dst_e,
    input  logic [DATA_W-1:0] e_val_e,
    input  logic [REG_W-1:0]  m_dst_m,
    input  logic [DATA_W-1:0] m_val_m,
    input  logic [REG_W-1:0]  m_dst_e,
    input  logic [DATA_W-1:0] m_val_e,
    input  logic [REG_W-1:0]  w_dst_m,
    input  logic [DATA_W-1:0] w_val_m,
    input  logic [REG_W-1:0]  w_dst_e,
    input  logic [DATA_W-1:0] w_val_e,
    output logic [DATA_W-1:0] val,
    output logic              hit
);

    // Both sides must name a real register for a match to count.
    function automatic logic reg_match(input logic [REG_W-1:0] s,
                                       input logic [REG_W-1:0] d);
        return (s != RNONE) && (d != RNONE) && (s == d);
    endfunction

    // First match wins; valP is not a forward, so it leaves hit low.
    always_comb begin
        val = rval;
        hit = 1'b0;
        if (USE_VALP && ((icode == ICODE_CALL) || (icode == ICODE_JXX))) begin
            val = valp;
        end else if (reg_match(src, e_dst_e)) begin
            val = e_val_e;
            hit = 1'b1;
        end else if (reg_match(src, m_dst_m)) begin
            val = m_val_m;
            hit = 1'b1;
        end else if (reg_match(src, m_dst_e)) begin
            val = m_val_e;
            hit = 1'b1;
        end else if (reg_match(src, w_dst_m)) begin
            val = w_val_m;
            hit = 1'b1;
        end else if (reg_match(src, w_dst_e)) begin
            val = w_val_e;
            hit = 1'b1;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use detection, D->E register and perf counters.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int               DATA_W = 64,
    parameter int               REG_W  = 4,
    parameter logic [REG_W-1:0] RNONE  = RNONE_ID,
    parameter int               CNT_W  = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    fwd_hazard_unit_if.slave bus
);

    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic              hit_a;
    logic              hit_b;
    logic              loaduse;
    logic              e_kill;
    logic [DATA_W-1:0] e_val_a_p1;
    logic [DATA_W-1:0] e_val_b_p1;
    logic              e_nop_p1;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    fwd_sel_chain #(
        .DATA_W(DATA_W), .REG_W(REG_W), .RNONE(RNONE), .USE_VALP(1'b1)
    ) u_sel_a (
        .icode  (bus.D_icode_i), .valp   (bus.D_valP_i),
        .src    (bus.d_srcA_i),  .rval   (bus.d_rvalA_i),
        .e_dst_e(bus.e_dstE_i),  .e_val_e(bus.e_valE_i),
        .m_dst_m(bus.M_dstM_i),  .m_val_m(bus.m_valM_i),
        .m_dst_e(bus.M_dstE_i),  .m_val_e(bus.M_valE_i),
        .w_dst_m(bus.W_dstM_i),  .w_val_m(bus.W_valM_i),
        .w_dst_e(bus.W_dstE_i),  .w_val_e(bus.W_valE_i),
        .val    (val_a),         .hit    (hit_a)
    );

    fwd_sel_chain #(
        .DATA_W(DATA_W), .REG_W(REG_W), .RNONE(RNONE), .USE_VALP(1'b0)
    ) u_sel_b (
        .icode  (bus.D_icode_i), .valp   (bus.D_valP_i),
        .src    (bus.d_srcB_i),  .rval   (bus.d_rvalB_i),
        .e_dst_e(bus.e_dstE_i),  .e_val_e(bus.e_valE_i),
        .m_dst_m(bus.M_dstM_i),  .m_val_m(bus.m_valM_i),
        .m_dst_e(bus.M_dstE_i),  .m_val_e(bus.M_valE_i),
        .w_dst_m(bus.W_dstM_i),  .w_val_m(bus.W_valM_i),
        .w_dst_e(bus.W_dstE_i),  .w_val_e(bus.W_valE_i),
        .val    (val_b),         .hit    (hit_b)
    );

    // A load in E whose destination is a real decode source must stall D.
    always_comb begin
        loaduse = 1'b0;
        if (is_load(bus.E_icode_i) && (bus.E_dstM_i != RNONE)) begin
            loaduse = ((bus.d_srcA_i != RNONE) && (bus.d_srcA_i == bus.E_dstM_i)) ||
                      ((bus.d_srcB_i != RNONE) && (bus.d_srcB_i == bus.E_dstM_i));
        end
    end

    assign e_kill = loaduse | bus.E_bubble_i;

    // D -> E stage boundary: a stall or external bubble inserts one nop.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || e_kill) begin
            e_val_a_p1 <= '0;
            e_val_b_p1 <= '0;
            e_nop_p1   <= 1'b1;
        end else begin
            e_val_a_p1 <= val_a;
            e_val_b_p1 <= val_b;
            e_nop_p1   <= 1'b0;
        end
    end

    // Performance counters: reset, then clear, then saturating increment.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || bus.cnt_clr_i) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (loaduse) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (!e_kill && (hit_a || hit_b)) begin
                fwd_cnt <= sat_inc(fwd_cnt);
            end
        end
    end

    assign bus.d_valA_o    = val_a;
    assign bus.d_valB_o    = val_b;
    assign bus.D_stall_o   = loaduse;
    assign bus.E_valA_o    = e_val_a_p1;
    assign bus.E_valB_o    = e_val_b_p1;
    assign bus.E_nop_o     = e_nop_p1;
    assign bus.stall_cnt_o = stall_cnt;
    assign bus.fwd_cnt_o   = fwd_cnt;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed vector bench for fwd_hazard_unit (4-bit counters to reach saturation).
module tb_fwd_hazard_unit;
    import fwd_hazard_unit_pkg::*;

    localparam int DW = 64;
    localparam int RW = 4;
    localparam int CW = 4;
    localparam logic [3:0] RN = 4'hF;

    typedef struct {
        logic [3:0]    d_icode;
        logic [DW-1:0] valp;
        logic [3:0]    src_a;
        logic [3:0]    src_b;
        logic [DW-1:0] rval_a;
        logic [DW-1:0] rval_b;
        logic [3:0]    e_icode;
        logic [3:0]    e_dstm;
        logic [3:0]    e_dste;
        logic [DW-1:0] e_vale;
        logic [3:0]    m_dstm;
        logic [DW-1:0] m_valm;
        logic [3:0]    m_dste;
        logic [DW-1:0] m_vale;
        logic [3:0]    w_dstm;
        logic [DW-1:0] w_valm;
        logic [3:0]    w_dste;
        logic [DW-1:0] w_vale;
        logic          bubble;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        logic          exp_stall;
        logic          exp_fwd;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   exp_stall_cnt = 0;
    int   exp_fwd_cnt   = 0;
    vec_t vq[$];
    vec_t v;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) bus ();

    fwd_hazard_unit #(.DATA_W(DW), .REG_W(RW), .RNONE(RN), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    function automatic vec_t dflt();
        vec_t x;
        x.d_icode = ICODE_NOP; x.valp = 64'h0;
        x.src_a = RN; x.src_b = RN;
        x.rval_a = 64'hA0A0; x.rval_b = 64'hB0B0;
        x.e_icode = ICODE_NOP; x.e_dstm = RN;
        x.e_dste = RN; x.e_vale = 64'h0;
        x.m_dstm = RN; x.m_valm = 64'h0;
        x.m_dste = RN; x.m_vale = 64'h0;
        x.w_dstm = RN; x.w_valm = 64'h0;
        x.w_dste = RN; x.w_vale = 64'h0;
        x.bubble = 1'b0;
        x.exp_a = 64'hA0A0; x.exp_b = 64'hB0B0;
        x.exp_stall = 1'b0; x.exp_fwd = 1'b0;
        return x;
    endfunction

    function automatic int sat(input int c);
        return (c < 15) ? c + 1 : 15;
    endfunction

    task automatic apply(input vec_t x);
        bus.D_icode_i = x.d_icode; bus.D_valP_i = x.valp;
        bus.d_srcA_i = x.src_a;    bus.d_srcB_i = x.src_b;
        bus.d_rvalA_i = x.rval_a;  bus.d_rvalB_i = x.rval_b;
        bus.E_icode_i = x.e_icode; bus.E_dstM_i = x.e_dstm;
        bus.e_dstE_i = x.e_dste;   bus.e_valE_i = x.e_vale;
        bus.M_dstM_i = x.m_dstm;   bus.m_valM_i = x.m_valm;
        bus.M_dstE_i = x.m_dste;   bus.M_valE_i = x.m_vale;
        bus.W_dstM_i = x.w_dstm;   bus.W_valM_i = x.w_valm;
        bus.W_dstE_i = x.w_dste;   bus.W_valE_i = x.w_vale;
        bus.E_bubble_i = x.bubble;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_stall_cnt"}, DW'(bus.stall_cnt_o), DW'(exp_stall_cnt));
        chk({tag, "_fwd_cnt"},   DW'(bus.fwd_cnt_o),   DW'(exp_fwd_cnt));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.cnt_clr_i = 1'b0;
        apply(dflt());
        tick();
        tick();
        chk("rst_nop",  DW'(bus.E_nop_o), 64'd1);
        chk("rst_ea",   bus.E_valA_o, 64'd0);
        chk("rst_eb",   bus.E_valB_o, 64'd0);
        chk_cnts("rst");
        rst_n = 1'b1;

        // 1: E beats M on srcA
        v = dflt(); v.src_a = 4'd3; v.e_dste = 4'd3; v.e_vale = 64'h11;
        v.m_dste = 4'd3; v.m_vale = 64'h22; v.rval_b = 64'h55;
        v.exp_a = 64'h11; v.exp_b = 64'h55; v.exp_fwd = 1'b1; vq.push_back(v);
        // 2: nothing forwards, RNONE everywhere
        v = dflt(); v.rval_a = 64'h66; v.rval_b = 64'h55;
        v.exp_a = 64'h66; v.exp_b = 64'h55; vq.push_back(v);
        // 3: M_dstM beats M_dstE and W; srcB from W_dstE
        v = dflt(); v.src_a = 4'd5; v.m_dstm = 4'd5; v.m_valm = 64'h33;
        v.m_dste = 4'd5; v.m_vale = 64'h44; v.w_dstm = 4'd5; v.w_valm = 64'h99;
        v.src_b = 4'd6; v.w_dste = 4'd6; v.w_vale = 64'h88;
        v.exp_a = 64'h33; v.exp_b = 64'h88; v.exp_fwd = 1'b1; vq.push_back(v);
        // 4: M_dstE beats W_dstM on both operands
        v = dflt(); v.src_a = 4'd7; v.src_b = 4'd7; v.m_dste = 4'd7; v.m_vale = 64'h44;
        v.w_dstm = 4'd7; v.w_valm = 64'h5A;
        v.exp_a = 64'h44; v.exp_b = 64'h44; v.exp_fwd = 1'b1; vq.push_back(v);
        // 5: W_dstM beats W_dstE; srcB misses
        v = dflt(); v.src_a = 4'd2; v.w_dstm = 4'd2; v.w_valm = 64'hAA;
        v.w_dste = 4'd2; v.w_vale = 64'hBB; v.src_b = 4'd9; v.rval_b = 64'h12;
        v.exp_a = 64'hAA; v.exp_b = 64'h12; v.exp_fwd = 1'b1; vq.push_back(v);
        // 6: CALL takes valP over an E forward, not counted
        v = dflt(); v.d_icode = ICODE_CALL; v.valp = 64'h40; v.src_a = 4'd4;
        v.e_dste = 4'd4; v.e_vale = 64'h11;
        v.exp_a = 64'h40; v.exp_b = 64'hB0B0; vq.push_back(v);
        // 7: JXX valP on A while B forwards from E
        v = dflt(); v.d_icode = ICODE_JXX; v.valp = 64'h80; v.src_b = 4'd4;
        v.e_dste = 4'd4; v.e_vale = 64'h11;
        v.exp_a = 64'h80; v.exp_b = 64'h11; v.exp_fwd = 1'b1; vq.push_back(v);
        // 8: RNONE source vs RNONE dest, real source vs RNONE dest
        v = dflt(); v.e_vale = 64'hDEAD; v.src_b = 4'd1; v.rval_b = 64'h77;
        v.m_valm = 64'hBEEF;
        v.exp_a = 64'hA0A0; v.exp_b = 64'h77; vq.push_back(v);
        // 9: external bubble suppresses register and fwd count
        v = dflt(); v.src_a = 4'd3; v.e_dste = 4'd3; v.e_vale = 64'h11; v.bubble = 1'b1;
        v.exp_a = 64'h11; vq.push_back(v);
        // 10: POPQ load-use on srcA
        v = dflt(); v.e_icode = ICODE_POPQ; v.e_dstm = 4'd4; v.src_a = 4'd4;
        v.exp_stall = 1'b1; vq.push_back(v);
        // 11: load-use and bubble together: one bubble, stall counted
        v = dflt(); v.e_icode = ICODE_MRMOVQ; v.e_dstm = 4'd2; v.src_b = 4'd2;
        v.bubble = 1'b1; v.exp_stall = 1'b1; vq.push_back(v);
        // 12: load with RNONE dest never stalls
        v = dflt(); v.e_icode = ICODE_MRMOVQ; vq.push_back(v);
        // 13: non-load writing the source does not stall
        v = dflt(); v.e_icode = ICODE_OPQ; v.e_dstm = 4'd2; v.src_a = 4'd2;
        v.rval_a = 64'h31; v.exp_a = 64'h31; vq.push_back(v);

        for (int i = 0; i < vq.size(); i++) begin
            string tag;
            logic  kill;
            tag = $sformatf("v%0d", i + 1);
            apply(vq[i]);
            #1;
            chk({tag, "_dvalA"}, bus.d_valA_o, vq[i].exp_a);
            chk({tag, "_dvalB"}, bus.d_valB_o, vq[i].exp_b);
            chk({tag, "_stall"}, DW'(bus.D_stall_o), DW'(vq[i].exp_stall));
            tick();
            kill = vq[i].exp_stall | vq[i].bubble;
            if (vq[i].exp_stall) exp_stall_cnt = sat(exp_stall_cnt);
            if (vq[i].exp_fwd) exp_fwd_cnt = sat(exp_fwd_cnt);
            chk({tag, "_EvalA"}, bus.E_valA_o, kill ? 64'd0 : vq[i].exp_a);
            chk({tag, "_EvalB"}, bus.E_valB_o, kill ? 64'd0 : vq[i].exp_b);
            chk({tag, "_Enop"},  DW'(bus.E_nop_o), DW'(kill));
            chk_cnts(tag);
        end

        // Load-use stall then the loaded value arrives via M_dstM
        v = dflt(); v.e_icode = ICODE_MRMOVQ; v.e_dstm = 4'd2; v.src_b = 4'd2;
        apply(v);
        #1;
        chk("lu_stall", DW'(bus.D_stall_o), 64'd1);
        tick();
        exp_stall_cnt = sat(exp_stall_cnt);
        chk("lu_nop", DW'(bus.E_nop_o), 64'd1);
        chk("lu_eb",  bus.E_valB_o, 64'd0);
        chk_cnts("lu");
        v = dflt(); v.src_b = 4'd2; v.m_dstm = 4'd2; v.m_valm = 64'h77;
        apply(v);
        #1;
        chk("lu2_stall", DW'(bus.D_stall_o), 64'd0);
        tick();
        exp_fwd_cnt = sat(exp_fwd_cnt);
        chk("lu2_eb",  bus.E_valB_o, 64'h77);
        chk("lu2_nop", DW'(bus.E_nop_o), 64'd0);
        chk_cnts("lu2");

        // Clear beats increment, then saturate the stall counter
        v = dflt(); v.e_icode = ICODE_MRMOVQ; v.e_dstm = 4'd6; v.src_a = 4'd6;
        apply(v);
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        exp_stall_cnt = 0;
        exp_fwd_cnt = 0;
        chk_cnts("clr1");
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_stall_cnt = sat(exp_stall_cnt);
            if (i == 14) chk_cnts("sat15");
        end
        chk_cnts("sat20");
        bus.cnt_clr_i = 1'b1;
        tick();
        bus.cnt_clr_i = 1'b0;
        exp_stall_cnt = 0;
        chk_cnts("clr2");
        tick();
        tick();
        exp_stall_cnt = 2;
        chk_cnts("post_clr");

        // Reset during an active load-use
        rst_n = 1'b0;
        #1;
        chk("rst_lu_stall", DW'(bus.D_stall_o), 64'd1);
        tick();
        exp_stall_cnt = 0;
        exp_fwd_cnt = 0;
        chk("rst_lu_nop", DW'(bus.E_nop_o), 64'd1);
        chk("rst_lu_ea",  bus.E_valA_o, 64'd0);
        chk("rst_lu_eb",  bus.E_valB_o, 64'd0);
        chk_cnts("rst_lu");
        rst_n = 1'b1;

        // Normal forward after reset release
        v = dflt(); v.src_a = 4'd1; v.w_dste = 4'd1; v.w_vale = 64'h1234;
        apply(v);
        tick();
        exp_fwd_cnt = sat(exp_fwd_cnt);
        chk("after_rst_ea",  bus.E_valA_o, 64'h1234);
        chk("after_rst_nop", DW'(bus.E_nop_o), 64'd0);
        chk_cnts("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
